// File: rtl/arb_mux_n_pkg.sv
// arb_mux_n_pkg: shared mode encodings and select-width helper for datapath muxes
package arb_mux_n_pkg;
  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// arb_mux_n_rr_arbiter: combinational round-robin grant, searching from the channel after ptr
module arb_mux_n_rr_arbiter #(
  parameter int N    = 5,
  parameter int SELW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_any_o
);
  logic [N-1:0] rot;
  int           first;
  int           idx;
  // rotate so bit 0 is the channel after ptr, then take the lowest set request
  always_comb begin
    rot = N'({req_i, req_i} >> (int'(ptr_i) + 1));
    first = 0;
    for (int j = N - 1; j >= 0; j--) first = rot[j] ? j : first;
    idx = int'(ptr_i) + 1 + first;
    idx = idx >= N ? idx - N : idx;
    gnt_idx_o = SELW'(idx);
  end
  assign gnt_any_o = |req_i;
endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-channel valid/ready mux, channel picked by select input or round-robin
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int W    = 16,
  parameter int N    = 5,
  parameter int SELW = sel_w(N),
  parameter int MODE = MODE_SEL
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N*W-1:0]  in_data_i,
  input  logic [N-1:0]    in_valid_i,
  output logic [N-1:0]    in_ready_o,
  input  logic [SELW-1:0] s_i,
  output logic [W-1:0]    o_o,
  output logic            o_valid_o,
  input  logic            o_ready_i,
  output logic [SELW-1:0] grant_o
);
  logic [W-1:0]    o_q, o_d, sel_data;
  logic [SELW-1:0] grant_q, grant_d, sel, rr_idx;
  logic            o_valid_q, o_valid_d, rr_any, hit, space, xfer;
  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] ptr_q;
    arb_mux_n_rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
      .req_i    (in_valid_i),
      .ptr_i    (ptr_q),
      .gnt_idx_o(rr_idx),
      .gnt_any_o(rr_any)
    );
    // pointer moves to the granted channel only when a word is actually taken
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) ptr_q <= SELW'(N - 1);
      else if (xfer) ptr_q <= sel;
  end else begin : g_sel
    assign rr_idx = '0;
    assign rr_any = 1'b0;
  end
  // channel choice and handshake; an out-of-range select shifts the one-hot away to nothing
  always_comb begin
    sel = MODE == MODE_RR ? rr_idx : s_i;
    hit = MODE == MODE_RR ? rr_any : |(in_valid_i & (N'(1) << s_i));
    space = !o_valid_q || o_ready_i;
    in_ready_o = rst_n_i && hit && space ? N'(1) << sel : '0;
    xfer = |in_ready_o;
  end
  // next output word: load on transfer, drop valid on drain, hold otherwise
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) sel_data = sel == SELW'(k) ? in_data_i[k*W +: W] : sel_data;
    o_d = xfer ? sel_data : o_q;
    grant_d = xfer ? sel : grant_q;
    o_valid_d = xfer || (o_valid_q && !o_ready_i);
  end
  // output register stage
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      o_q <= '0;
      grant_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_q <= o_d;
      grant_q <= grant_d;
      o_valid_q <= o_valid_d;
    end
  assign o_o = o_q;
  assign o_valid_o = o_valid_q;
  assign grant_o = grant_q;
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: select-mode and round-robin instances checked against a bench model and directed vectors
module tb_arb_mux_n;
  localparam int W = 16;
  localparam int N = 5;
  localparam int SELW = 3;
  logic clk;
  logic rst_n = 1'b1;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [SELW-1:0] s;
  logic o_ready;
  logic [N-1:0] rdy [2];
  logic [W-1:0] o [2];
  logic ov [2];
  logic [SELW-1:0] g [2];
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] m_o [2];
  logic m_v [2];
  logic [SELW-1:0] m_g [2];
  int m_ptr;
  int fair [6] = '{0, 1, 2, 3, 4, 0};
  int pair [4] = '{1, 4, 1, 4};

  arb_mux_n #(.W(W), .N(N), .SELW(SELW), .MODE(0)) u_sel (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy[0]), .s_i(s), .o_o(o[0]), .o_valid_o(ov[0]), .o_ready_i(o_ready), .grant_o(g[0]));
  arb_mux_n #(.W(W), .N(N), .SELW(SELW), .MODE(1)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy[1]), .s_i(s), .o_o(o[1]), .o_valid_o(ov[1]), .o_ready_i(o_ready), .grant_o(g[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int m);
    int p;
    p = -1;
    if (m == 0) begin
      if (int'(s) < N && in_valid[s]) p = int'(s);
    end else
      for (int d = 1; d <= N; d++)
        if (p < 0 && in_valid[(m_ptr + d) % N]) p = (m_ptr + d) % N;
    return p;
  endfunction

  function automatic logic [N-1:0] exp_rdy(input int m);
    int p;
    p = pick(m);
    return (rst_n && p >= 0 && (!m_v[m] || o_ready)) ? N'(1) << p : '0;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_o[m] <= '0;
        m_v[m] <= 1'b0;
        m_g[m] <= '0;
      end
      m_ptr <= N - 1;
    end else
      for (int m = 0; m < 2; m++) begin
        if (exp_rdy(m) != '0) begin
          m_o[m] <= in_data[pick(m)*W +: W];
          m_g[m] <= SELW'(pick(m));
          m_v[m] <= 1'b1;
          if (m == 1) m_ptr <= pick(m);
        end else if (o_ready) m_v[m] <= 1'b0;
      end

  always @(negedge clk)
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("model m%0d in_ready", m), 32'(rdy[m]), 32'(exp_rdy(m)));
      chk($sformatf("model m%0d o", m), 32'(o[m]), 32'(m_o[m]));
      chk($sformatf("model m%0d o_valid", m), 32'(ov[m]), 32'(m_v[m]));
      chk($sformatf("model m%0d grant", m), 32'(g[m]), 32'(m_g[m]));
    end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    tick();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    in_data = '0;
    in_valid = '0;
    s = '0;
    o_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("reset o", 32'(o[m]), 32'h0);
      chk("reset o_valid", 32'(ov[m]), 32'h0);
      chk("reset grant", 32'(g[m]), 32'h0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(32'h1000 + k);
    in_data[3*W +: W] = 16'hBEEF;
    in_valid = '1;
    s = 3'd3;
    o_ready = 1'b1;
    #2 chk("sel s3 in_ready", 32'(rdy[0]), 32'b01000);
    tick();
    s = 3'd7;
    #2 chk("sel s3 o", 32'(o[0]), 32'hBEEF);
    chk("sel s3 grant", 32'(g[0]), 32'd3);
    chk("sel s3 o_valid", 32'(ov[0]), 32'd1);
    chk("sel s7 in_ready", 32'(rdy[0]), 32'h0);
    tick();
    chk("sel s7 drained", 32'(ov[0]), 32'h0);
    chk("sel s7 o kept", 32'(o[0]), 32'hBEEF);
    s = 3'd0;
    in_data[0 +: W] = 16'h0001;
    tick();
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data[0 +: W] = W'(32'h2000 + i);
      s = SELW'(i + 1);
      #2 chk("stall o", 32'(o[0]), 32'h0001);
      chk("stall in_ready", 32'(rdy[0]), 32'h0);
      chk("stall o_valid", 32'(ov[0]), 32'd1);
      tick();
    end
    o_ready = 1'b1;
    s = 3'd0;
    in_data[0 +: W] = 16'hABCD;
    #2 chk("release in_ready", 32'(rdy[0]), 32'b00001);
    tick();
    chk("release o", 32'(o[0]), 32'hABCD);
    rst_pulse();
    in_valid = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr fair %0d", i), 32'(g[1]), 32'(fair[i]));
    end
    in_valid = 5'b10010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr pair %0d", i), 32'(g[1]), 32'(pair[i]));
    end
    rst_pulse();
    in_valid = 5'b00101;
    tick();
    chk("hold first", 32'(g[1]), 32'd0);
    o_ready = 1'b0;
    tick();
    chk("hold stall1", 32'(g[1]), 32'd0);
    tick();
    chk("hold stall2", 32'(g[1]), 32'd0);
    o_ready = 1'b1;
    tick();
    chk("hold after1", 32'(g[1]), 32'd2);
    tick();
    chk("hold after2", 32'(g[1]), 32'd0);
    rst_pulse();
    in_valid = 5'b00100;
    s = 3'd2;
    for (int i = 0; i < 10; i++) begin
      in_data[2*W +: W] = W'(32'h3000 + i);
      tick();
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("tput m%0d o %0d", m, i), 32'(o[m]), 32'h3000 + i);
        chk($sformatf("tput m%0d valid %0d", m, i), 32'(ov[m]), 32'd1);
      end
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async o", 32'(o[m]), 32'h0);
      chk("async o_valid", 32'(ov[m]), 32'h0);
      chk("async grant", 32'(g[m]), 32'h0);
      chk("async in_ready", 32'(rdy[m]), 32'h0);
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
